controle_varredura_pwm: RTL and testbench
=========================================

# controle_varredura_pwm

Sequencer for the servo PWM generator `circuito_pwm`. After a start request it drives the generator's 2-bit `largura` select through a fixed sweep, 00→01→10→11→10→01→00, and holds each position for a programmable dwell time. It sits between the top-level control (buttons or the host FSM) and `circuito_pwm`, and is the only driver of `largura`.

## Interface
Parameters:
- `CONF_DWELL`, default 25_000_000: clock cycles counted in ESPERA per position (500 ms at 50 MHz); must be ≥ 1.

Ports:
- `clock`  in  1  system clock, 50 MHz, rising edge.
- `reset`  in  1  synchronous, active-high; dominates every other input.
- `iniciar`  in  1  start request, level-sampled, only acted on in INICIAL.
- `parar`  in  1  abort request, level-sampled; has priority over `iniciar`.
- `largura`  out  2  position select to `circuito_pwm.largura`, registered.
- `ativo`  out  1  high while a sweep is in progress, registered.
- `fim`  out  1  one-cycle pulse when a sweep completes, registered.
- `db_estado`  out  3  current FSM state encoding, for debug/7-seg.

Clock `clock`; reset `reset` is synchronous and active-high.

## Operation
- States: INICIAL(0), PREPARA(1), ESPERA(2), PROXIMA(3), FIM(4). Moore FSM; all outputs registered.
- Reset: state INICIAL, `largura`=00, `ativo`=0, `fim`=0, dwell counter=0, `sentido`=subida.
- INICIAL: `iniciar`=1 and `parar`=0 → PREPARA. Otherwise stay.
- PREPARA (1 cycle): clear the counter, `largura`=00, `sentido`=subida, `ativo`=1 → ESPERA.
- ESPERA: counter increments each cycle. When count = CONF_DWELL−1, clear it → PROXIMA.
- PROXIMA (1 cycle):
  - subida and `largura`≠11 → `largura`+1.
  - subida and `largura`=11 → `sentido`=descida, `largura`=10.
  - descida and `largura`≠00 → `largura`−1.
  - In all three cases above, → ESPERA.
  - descida and `largura`=00 → FIM.
- FIM (1 cycle): `fim`=1, `ativo`=0, `largura`=00 → INICIAL.
- `parar`=1 in any state other than INICIAL → INICIAL on the next edge. `largura`=00, `ativo`=0, counter cleared, no `fim` pulse.
- `iniciar` outside INICIAL is ignored. `iniciar` still high on return to INICIAL starts a new sweep one cycle after FIM.
- Counter width is $clog2(CONF_DWELL+1). It never exceeds CONF_DWELL−1.

## Timing
- `iniciar` sampled at edge k → PREPARA at k+1, `ativo`=1 visible at k+1.
- Each position is held exactly CONF_DWELL+1 cycles: the first 00 through PREPARA+ESPERA, the others through ESPERA+PROXIMA.
- FIM is entered 7·(CONF_DWELL+1) cycles after PREPARA is entered. `fim` is high for exactly 1 cycle, then INICIAL.
- `parar` sampled at edge k → INICIAL, `largura`=00 and `ativo`=0 at k+1.
- `reset` and `parar` asserted together behave as reset.
- `largura` only changes on PREPARA/PROXIMA/FIM/abort edges. `circuito_pwm` picks up the new width at its next period boundary; that is outside this block.

## Configuration
- `VARREDURA_CONTINUA_EN` defined:
  - PROXIMA with descida and `largura`=00 does not go to FIM. It sets `sentido`=subida, `largura`=01 and pulses `fim` for that one cycle, → ESPERA.
  - The sweep repeats until `parar` or `reset`; `ativo` stays 1.
  - The 00 position at a turnaround is held CONF_DWELL+1 cycles, not doubled.
- Not defined: single sweep as in Operation.

## Structure
- Package `varredura_pwm_pkg`:
  - state encodings INICIAL..FIM (3-bit);
  - position constants POS_00..POS_11;
  - `sentido` encoding.
- Sub-module `contador_dwell`: parameterised modulo-CONF_DWELL counter with `zera`, `conta`, and a registered-compare `fim_contagem` pulse.
- FSM and position/direction registers stay in `controle_varredura_pwm`.

## Test plan
All cases use CONF_DWELL=10, so each position is held 11 cycles.
- Reset: assert `reset` 1 cycle → `largura`=00, `ativo`=0, `fim`=0, `db_estado`=0. Hold `iniciar`=0 for 20 cycles → no change.
- Full sweep: 1-cycle `iniciar` pulse → `largura` runs 00,01,10,11,10,01,00, 11 cycles each. `fim`=1 for 1 cycle exactly 77 cycles after PREPARA, then `ativo`=0.
- Abort at position 11: `parar` pulse → next cycle `largura`=00, `ativo`=0, `db_estado`=0, and `fim` never pulses. A new `iniciar` restarts from 00.
- Ignored and simultaneous requests: `iniciar` pulsed during ESPERA → sequence unchanged. `iniciar`=`parar`=1 in INICIAL → stays INICIAL.
- Reset mid-sweep: `reset` at position 10 with `parar`=1 → all outputs at reset values next cycle.
- With `VARREDURA_CONTINUA_EN`:
  - `iniciar` once → `fim` pulses at cycles 77, 143, 209 after PREPARA; `ativo` stays 1.
  - `parar` → INICIAL within 1 cycle.

Source files
------------

// File: rtl/varredura_pwm_pkg.sv
// Shared encodings for the servo sweep sequencer:
// FSM states, position selects and sweep direction.
package varredura_pwm_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    ESPERA  = 3'd2,
    PROXIMA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [1:0] POS_00 = 2'b00;
  localparam logic [1:0] POS_01 = 2'b01;
  localparam logic [1:0] POS_10 = 2'b10;
  localparam logic [1:0] POS_11 = 2'b11;

  typedef enum logic {
    SUBIDA  = 1'b0,
    DESCIDA = 1'b1
  } sentido_t;

endpackage

// File: rtl/controle_varredura_pwm_if.sv
// Control/status bundle between the top-level control
// and the sweep sequencer.
interface controle_varredura_pwm_if;

  logic       iniciar;
  logic       parar;
  logic [1:0] largura;
  logic       ativo;
  logic       fim;
  logic [2:0] db_estado;

  modport master (
    output iniciar,
    output parar,
    input  largura,
    input  ativo,
    input  fim,
    input  db_estado
  );

  modport slave (
    input  iniciar,
    input  parar,
    output largura,
    output ativo,
    output fim,
    output db_estado
  );

endinterface

// File: rtl/controle_varredura_pwm_contador.sv
// Modulo-CONF_DWELL dwell counter with a registered
// end-of-count flag aligned to the last count.
module contador_dwell #(
  parameter int CONF_DWELL = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_contagem
);

  localparam int W = $clog2(CONF_DWELL + 1);
  localparam logic [W-1:0] ULTIMO = W'(CONF_DWELL - 1);
  localparam logic [W-1:0] UM = W'(1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_prox;
  logic         r_fim;

  always_comb begin
    w_prox = r_cnt;
    if (zera) begin
      w_prox = '0;
    end else if (conta) begin
      w_prox = (r_cnt == ULTIMO) ? '0 : r_cnt + UM;
    end
  end

  // Flag compares the value being loaded, so it is high
  // during the very cycle the counter holds ULTIMO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_fim <= 1'b0;
    end else begin
      r_cnt <= w_prox;
      r_fim <= (w_prox == ULTIMO);
    end
  end

  assign fim_contagem = r_fim;

endmodule

// File: rtl/controle_varredura_pwm.sv
// Servo sweep sequencer driving circuito_pwm.largura.
// Define VARREDURA_CONTINUA_EN for an endless sweep.
module controle_varredura_pwm
  import varredura_pwm_pkg::*;
#(
  parameter int CONF_DWELL = 25_000_000
) (
  input logic              clock,
  input logic              reset,
  controle_varredura_pwm_if.slave bus
);

  estado_t    r_estado, w_prox_estado;
  sentido_t   r_sentido, w_prox_sentido;
  logic [1:0] r_largura, w_prox_largura;
  logic       r_ativo, w_prox_ativo;
  logic       r_fim, w_prox_fim;
  logic       w_zera;
  logic       w_conta;
  logic       w_fim_contagem;

  assign w_conta = (r_estado == ESPERA);
  assign w_zera  = ~w_conta | bus.parar;

  contador_dwell #(
    .CONF_DWELL (CONF_DWELL)
  ) u_contador (
    .clock        (clock),
    .reset        (reset),
    .zera         (w_zera),
    .conta        (w_conta),
    .fim_contagem (w_fim_contagem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= INICIAL;
      r_sentido <= SUBIDA;
      r_largura <= POS_00;
      r_ativo   <= 1'b0;
      r_fim     <= 1'b0;
    end else begin
      r_estado  <= w_prox_estado;
      r_sentido <= w_prox_sentido;
      r_largura <= w_prox_largura;
      r_ativo   <= w_prox_ativo;
      r_fim     <= w_prox_fim;
    end
  end

  always_comb begin
    w_prox_estado  = r_estado;
    w_prox_sentido = r_sentido;
    w_prox_largura = r_largura;
    w_prox_ativo   = r_ativo;
    w_prox_fim     = 1'b0;
    if (bus.parar && r_estado != INICIAL) begin
      w_prox_estado  = INICIAL;
      w_prox_largura = POS_00;
      w_prox_ativo   = 1'b0;
    end else begin
      unique case (r_estado)
        INICIAL: begin
          if (bus.iniciar && !bus.parar) begin
            w_prox_estado  = PREPARA;
            w_prox_sentido = SUBIDA;
            w_prox_largura = POS_00;
            w_prox_ativo   = 1'b1;
          end
        end
        PREPARA: w_prox_estado = ESPERA;
        // Step is computed at dwell end so the new width
        // is already registered while in PROXIMA.
        ESPERA: begin
          if (w_fim_contagem) begin
            w_prox_estado = PROXIMA;
            if (r_sentido == SUBIDA) begin
              if (r_largura == POS_11) begin
                w_prox_sentido = DESCIDA;
                w_prox_largura = POS_10;
              end else begin
                w_prox_largura = r_largura + 2'd1;
              end
            end else if (r_largura != POS_00) begin
              w_prox_largura = r_largura - 2'd1;
            end else begin
`ifdef VARREDURA_CONTINUA_EN
              w_prox_sentido = SUBIDA;
              w_prox_largura = POS_01;
              w_prox_fim     = 1'b1;
`else
              w_prox_estado  = FIM;
              w_prox_largura = POS_00;
              w_prox_ativo   = 1'b0;
              w_prox_fim     = 1'b1;
`endif
            end
          end
        end
        PROXIMA: w_prox_estado = ESPERA;
        FIM:     w_prox_estado = INICIAL;
        default: begin
          w_prox_estado  = INICIAL;
          w_prox_largura = POS_00;
          w_prox_ativo   = 1'b0;
        end
      endcase
    end
  end

  assign bus.largura   = r_largura;
  assign bus.ativo     = r_ativo;
  assign bus.fim       = r_fim;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_controle_varredura_pwm.sv
// Bench for controle_varredura_pwm with CONF_DWELL=10,
// checked cycle by cycle against a timeline model.
module tb_controle_varredura_pwm;

  localparam int D = 10;
  localparam int H = D + 1;
`ifdef VARREDURA_CONTINUA_EN
  localparam bit CONTINUA = 1'b1;
`else
  localparam bit CONTINUA = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   SEQ [7] = '{0, 1, 2, 3, 2, 1, 0};

  controle_varredura_pwm_if bus ();

  controle_varredura_pwm #(
    .CONF_DWELL (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Expected {largura, ativo, fim} t cycles after PREPARA.
  function automatic logic [3:0] modelo(int t);
    int u;
    if (t < 7 * H) return {2'(SEQ[t / H]), 2'b10};
    if (CONTINUA) begin
      u = (t - 7 * H) % (6 * H);
      return {2'(SEQ[1 + u / H]), 1'b1, u == 0};
    end
    return (t == 7 * H) ? 4'b0001 : 4'b0000;
  endfunction

  task automatic start_sweep();
    @(negedge clock);
    bus.iniciar = 1'b1;
    @(posedge clock);
    #1 bus.iniciar = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clock);
    bus.parar = 1'b1;
    @(posedge clock);
    #1 bus.parar = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
    reset       = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    obs = {bus.largura, bus.ativo, bus.fim};
    checks++;
    if (obs !== 4'b0000 || bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL reset out=%b st=%0d want 0000 st=0",
               obs, bus.db_estado);
    end
    for (int i = 0; i < 20; i++) begin
      bus.parar = 1'($urandom_range(0, 1));
      @(negedge clock);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== 4'b0000 || bus.db_estado !== 3'd0) begin
        errors++;
        $display("FAIL idle i=%0d out=%b st=%0d want 0000 st=0",
                 i, obs, bus.db_estado);
      end
    end
    bus.parar = 1'b0;
  endtask

  task automatic test_full_sweep();
    logic [3:0] obs, exp;
    int last;
    last = CONTINUA ? (7 * H + 12 * H + 6) : (7 * H + 3);
    repeat ($urandom_range(0, 5)) @(posedge clock);
    start_sweep();
    for (int t = 0; t <= last; t++) begin
      @(negedge clock);
      exp = modelo(t);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sweep t=%0d got %b want %b", t, obs, exp);
      end
      if (t == 0) begin
        checks++;
        if (bus.db_estado !== 3'd1) begin
          errors++;
          $display("FAIL prepara st=%0d want 1", bus.db_estado);
        end
      end
    end
    go_idle();
    @(negedge clock);
    checks++;
    if (bus.db_estado !== 3'd0 || bus.ativo !== 1'b0) begin
      errors++;
      $display("FAIL sweep_stop st=%0d ativo=%b want 0 0",
               bus.db_estado, bus.ativo);
    end
  endtask

  task automatic test_abort();
    logic [3:0] obs, exp;
    bit seen;
    int tab;
    tab = $urandom_range(3 * H, 4 * H - 1);
    start_sweep();
    for (int t = 0; t <= tab; t++) begin
      @(negedge clock);
      exp = modelo(t);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_pre t=%0d got %b want %b", t, obs, exp);
      end
    end
    bus.parar = 1'b1;
    @(posedge clock);
    #1 bus.parar = 1'b0;
    @(negedge clock);
    obs = {bus.largura, bus.ativo, bus.fim};
    checks++;
    if (obs !== 4'b0000 || bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL abort out=%b st=%0d want 0000 st=0",
               obs, bus.db_estado);
    end
    seen = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (bus.fim !== 1'b0 || bus.db_estado !== 3'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_quiet got activity=1 want 0");
    end
    start_sweep();
    for (int t = 0; t <= 2 * H; t++) begin
      @(negedge clock);
      exp = modelo(t);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL restart t=%0d got %b want %b", t, obs, exp);
      end
    end
    go_idle();
  endtask

  task automatic test_ignored();
    logic [3:0] obs, exp;
    int n;
    start_sweep();
    for (int t = 0; t <= 7 * H + 3; t++) begin
      @(negedge clock);
      exp = modelo(t);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ignored t=%0d got %b want %b", t, obs, exp);
      end
      bus.iniciar = (t < 7 * H - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    go_idle();
    @(negedge clock);
    bus.iniciar = 1'b1;
    bus.parar   = 1'b1;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checks++;
      if (bus.db_estado !== 3'd0 || bus.ativo !== 1'b0) begin
        errors++;
        $display("FAIL both i=%0d st=%0d ativo=%b want 0 0",
                 i, bus.db_estado, bus.ativo);
      end
    end
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs, exp;
    int tr;
    tr = $urandom_range(2 * H, 3 * H - 1);
    start_sweep();
    for (int t = 0; t <= tr; t++) begin
      @(negedge clock);
      exp = modelo(t);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rmid_pre t=%0d got %b want %b", t, obs, exp);
      end
    end
    reset     = 1'b1;
    bus.parar = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    bus.parar = 1'b0;
    @(negedge clock);
    obs = {bus.largura, bus.ativo, bus.fim};
    checks++;
    if (obs !== 4'b0000 || bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid out=%b st=%0d want 0000 st=0",
               obs, bus.db_estado);
    end
    start_sweep();
    for (int t = 0; t <= 3 * H; t++) begin
      @(negedge clock);
      exp = modelo(t);
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rmid_post t=%0d got %b want %b", t, obs, exp);
      end
    end
    go_idle();
  endtask

`ifndef VARREDURA_CONTINUA_EN
  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    @(negedge clock);
    bus.iniciar = 1'b1;
    @(posedge clock);
    for (int t = 0; t <= 7 * H + 2; t++) begin
      @(negedge clock);
      exp = (t <= 7 * H + 1) ? modelo(t) : 4'b0010;
      obs = {bus.largura, bus.ativo, bus.fim};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b t=%0d got %b want %b", t, obs, exp);
      end
      if (t == 7 * H + 2) begin
        checks++;
        if (bus.db_estado !== 3'd1) begin
          errors++;
          $display("FAIL b2b_restart st=%0d want 1", bus.db_estado);
        end
      end
    end
    bus.iniciar = 1'b0;
    go_idle();
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
    test_reset();
    test_full_sweep();
    test_abort();
    test_ignored();
    test_reset_mid();
`ifndef VARREDURA_CONTINUA_EN
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
